pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard / stall controller for a 5-stage in-order pipeline.
// Resolves load-use hazards, taken-branch flushes and memory-miss freezes.
// A memory timeout leads to a sticky error. Stall and flush performance
// counters saturate at all-ones.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             pipe_hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              lu, ms;

  assign lu = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
              ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) ||
               (ID_EX_RTaddr_i == IF_ID_RTaddr_i));
  assign ms = mem_req_i && !mem_ack_i;

  // State register, wait counter and performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next-state and same-cycle control decode; reset cycle forces run outputs.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_hold_o    = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        RUN: begin
          if (ms) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
            state_d       = MEM_WAIT;
            wait_d        = '0;
          end else if (lu) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            IF_ID_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          PC_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
          pipe_hold_o   = 1'b1;
          if (mem_ack_i) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ERR: begin
          PC_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
          pipe_hold_o   = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!PC_write_o && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
    if (IF_ID_flush_o && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_W'(1);
  end

  assign err_o       = (state_q == ERR);
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipeline_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       branch;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       hold;
  logic       err;
  logic [2:0] stall_cnt;
  logic [2:0] flush_cnt;
  logic [4:0] ctrl;

  int n_vec = 0;
  int n_err = 0;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_EX_MemRead_i(mem_read),
    .ID_EX_RTaddr_i (ex_rt),
    .IF_ID_RSaddr_i (id_rs),
    .IF_ID_RTaddr_i (id_rt),
    .branch_taken_i (branch),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .PC_write_o     (pc_write),
    .IF_ID_write_o  (ifid_write),
    .IF_ID_flush_o  (ifid_flush),
    .ID_EX_bubble_o (idex_bubble),
    .pipe_hold_o    (hold),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold}
  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, hold};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs then change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before next edge).
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    branch = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    mem_req = 1'b1;
    #4;
    chk("reset_cycle_ctrl", 8'(ctrl), 8'b11000);
    tick();

    // load-use: EX load RT=5, ID RS=5
    rst = 1'b0; idle_inputs();
    mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    settle();
    chk("post_reset_stall", 8'(stall_cnt), 8'd0);
    chk("post_reset_flush", 8'(flush_cnt), 8'd0);
    chk("post_reset_err", 8'(err), 8'd0);
    chk("lu_ctrl", 8'(ctrl), 8'b00010);
    tick();

    idle_inputs();
    settle();
    chk("lu_release_ctrl", 8'(ctrl), 8'b11000);
    chk("lu_stall_cnt", 8'(stall_cnt), 8'd1);
    tick();

    // load into $zero is never a hazard
    mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    settle();
    chk("zero_ctrl", 8'(ctrl), 8'b11000);
    tick();

    // load-use on RT plus taken branch: hazard wins, branch dropped
    mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; branch = 1'b1;
    settle();
    chk("zero_stall_cnt", 8'(stall_cnt), 8'd1);
    chk("prio_ctrl", 8'(ctrl), 8'b00010);
    tick();

    // branch alone next cycle
    idle_inputs(); branch = 1'b1;
    settle();
    chk("prio_flush_cnt", 8'(flush_cnt), 8'd0);
    chk("prio_stall_cnt", 8'(stall_cnt), 8'd2);
    chk("branch_ctrl", 8'(ctrl), 8'b11100);
    tick();

    idle_inputs(); rst = 1'b1;
    settle();
    chk("branch_flush_cnt", 8'(flush_cnt), 8'd1);
    chk("reset2_ctrl", 8'(ctrl), 8'b11000);
    tick();

    // miss: request in RUN, ack on 4th MEM_WAIT cycle (the timeout boundary)
    rst = 1'b0; mem_req = 1'b1;
    settle();
    chk("reset2_stall", 8'(stall_cnt), 8'd0);
    chk("reset2_flush", 8'(flush_cnt), 8'd0);
    chk("miss_run_ctrl", 8'(ctrl), 8'b00001);
    tick();
    settle();
    chk("miss_w0_ctrl", 8'(ctrl), 8'b00001);
    tick();
    mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; branch = 1'b1;
    settle();
    chk("miss_w1_ignore_ctrl", 8'(ctrl), 8'b00001);
    tick();
    mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; branch = 1'b0;
    settle();
    chk("miss_w2_ctrl", 8'(ctrl), 8'b00001);
    tick();
    mem_ack = 1'b1;
    settle();
    chk("miss_ack_ctrl", 8'(ctrl), 8'b00001);
    chk("miss_ack_err", 8'(err), 8'd0);
    tick();
    idle_inputs();
    settle();
    chk("miss_back_run_ctrl", 8'(ctrl), 8'b11000);
    chk("miss_stall_cnt", 8'(stall_cnt), 8'd5);
    chk("miss_no_err", 8'(err), 8'd0);
    tick();

    // hit: req and ack together means no stall
    mem_req = 1'b1; mem_ack = 1'b1;
    settle();
    chk("hit_ctrl", 8'(ctrl), 8'b11000);
    tick();
    idle_inputs(); rst = 1'b1;
    settle();
    chk("hit_stall_cnt", 8'(stall_cnt), 8'd5);
    tick();

    // timeout: no ack, ERR after 4 MEM_WAIT cycles; also 9 stall cycles saturate
    rst = 1'b0; mem_req = 1'b1;
    settle();
    chk("to_start_stall", 8'(stall_cnt), 8'd0);
    chk("to_run_ctrl", 8'(ctrl), 8'b00001);
    tick();
    mem_req = 1'b0;
    tick();
    tick();
    tick();
    settle();
    chk("to_last_wait_err", 8'(err), 8'd0);
    chk("to_last_wait_ctrl", 8'(ctrl), 8'b00001);
    chk("to_stall_4", 8'(stall_cnt), 8'd4);
    tick();
    mem_ack = 1'b1; branch = 1'b1;
    settle();
    chk("err_set", 8'(err), 8'd1);
    chk("err_ctrl", 8'(ctrl), 8'b00001);
    chk("err_stall_5", 8'(stall_cnt), 8'd5);
    tick();
    settle();
    chk("err_stall_6", 8'(stall_cnt), 8'd6);
    chk("err_held", 8'(err), 8'd1);
    tick();
    settle();
    chk("err_stall_7", 8'(stall_cnt), 8'd7);
    tick();
    tick();
    settle();
    chk("sat_stall_cnt", 8'(stall_cnt), 8'd7);
    chk("err_still_held", 8'(err), 8'd1);
    chk("err_still_ctrl", 8'(ctrl), 8'b00001);
    rst = 1'b1;
    #1;
    chk("err_reset_cycle_ctrl", 8'(ctrl), 8'b11000);
    tick();

    rst = 1'b0; idle_inputs();
    settle();
    chk("err_cleared", 8'(err), 8'd0);
    chk("err_rst_stall", 8'(stall_cnt), 8'd0);
    chk("err_rst_run_ctrl", 8'(ctrl), 8'b11000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
